// File: rtl/mutex_req_ctl.sv
// mutex_req_ctl: per-port four-phase request front end for an asynchronous M-to-1 mutex arbiter.
// Define MUTEX_REQ_SYNC_EN for a two-flop grant synchroniser; otherwise a single register stage is used.
`timescale 1ns/1ps
module mutex_req_ctl #(
   parameter int wd   = 4,
   parameter int HOLD = 8,
   parameter int HW   = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [wd-1:0] cli_req,
   output logic [wd-1:0] cli_gnt,
   output logic [wd-1:0] cli_exp,
   output logic [wd-1:0] arb_req,
   input  logic [wd-1:0] arb_gnt,
   output logic          err
);
   typedef enum logic [1:0] {IDLE, WAIT, OWN, REL} state_t;
   logic [wd-1:0] gnt_s;
`ifdef MUTEX_REQ_SYNC_EN
   logic [wd-1:0] gnt_m;
   always_ff @(posedge clk) begin
      gnt_m <= rst ? '0 : arb_gnt;
      gnt_s <= rst ? '0 : gnt_m;
   end
`else
   always_ff @(posedge clk)
      gnt_s <= rst ? '0 : arb_gnt;
`endif
   // more than one bit set means the mutex broke its exclusion guarantee
   always_ff @(posedge clk)
      err <= rst ? 1'b0 : err | ((gnt_s & (gnt_s - wd'(1))) != '0);
   for (genvar i = 0; i < wd; i++) begin : g_port
      state_t st, nx;
      logic [HW-1:0] cnt;
      logic lim, exp_q;
      assign lim = (HOLD != 0) && (cnt == HW'(HOLD - 1));
      assign arb_req[i] = (st == WAIT) || (st == OWN);
      assign cli_gnt[i] = st == OWN;
      assign cli_exp[i] = exp_q;
      always_comb begin
         nx = st;
         case (st)
            IDLE: nx = (cli_req[i] && !gnt_s[i]) ? WAIT : IDLE;
            WAIT: nx = !cli_req[i] ? REL : gnt_s[i] ? OWN : WAIT;
            OWN:  nx = (!cli_req[i] || lim) ? REL : OWN;
            default: nx = (!gnt_s[i] && !cli_req[i]) ? IDLE : REL;
         endcase
      end
      // cnt rests at zero outside OWN, so it is already clear on entry
      always_ff @(posedge clk) begin
         if (rst) begin
            st    <= IDLE;
            cnt   <= '0;
            exp_q <= 1'b0;
         end else begin
            st    <= nx;
            cnt   <= (st != OWN) ? '0 : (cnt != '1) ? cnt + HW'(1) : cnt;
            exp_q <= (st == OWN) && cli_req[i] && lim;
         end
      end
   end
endmodule

// File: tb/tb_mutex_req_ctl.sv
// tb_mutex_req_ctl: randomized and directed bench for mutex_req_ctl against a behavioural mutex arbiter
// and an ownership-level reference model.
`timescale 1ns/1ps
module tb_mutex_req_ctl;
   localparam int wd = 4, HOLD = 8, HW = 4;
`ifdef MUTEX_REQ_SYNC_EN
   localparam int LAG = 2;
`else
   localparam int LAG = 1;
`endif
   logic clk = 1'b0, rst = 1'b1, err;
   logic [wd-1:0] cli_req = '0, arb_gnt = '0, cli_gnt, cli_exp, arb_req;
   int errors = 0, checks = 0;
   bit fault = 1'b0;
   int holder = -1, edges = 0, multi_at = -1;
   int run_len [wd] = '{default: 0};
   logic [wd-1:0] last_gnt = '0, blocked = '0;

   mutex_req_ctl #(.wd(wd), .HOLD(HOLD), .HW(HW)) dut (
      .clk(clk), .rst(rst), .cli_req(cli_req), .cli_gnt(cli_gnt), .cli_exp(cli_exp),
      .arb_req(arb_req), .arb_gnt(arb_gnt), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // mutex model: one holder at a time, grant follows request within about 1 ns
   initial begin
      int k;
      #0.5;
      forever begin
         if (holder >= 0 && !arb_req[holder]) holder = -1;
         if (holder < 0 && arb_req != '0) begin
            k = $urandom_range(0, wd - 1);
            while (!arb_req[k]) k = (k + 1) % wd;
            holder = k;
         end
         arb_gnt = fault ? 4'b0011 : (holder >= 0 ? (wd'(1) << holder) : '0);
         #1;
      end
   end

   // edge index at which a multi-hot grant was first captured since reset
   always @(posedge clk) begin
      if (rst) multi_at = -1;
      else if (multi_at < 0 && $countones(arb_gnt) > 1) multi_at = edges;
      edges++;
   end

   task automatic step();
      logic [wd-1:0] full, xexp;
      @(negedge clk);
      for (int i = 0; i < wd; i++) full[i] = last_gnt[i] && run_len[i] == HOLD;
      xexp = rst ? '0 : full & cli_req;
      check("exp", cli_exp, xexp);
      check("onehot", $countones(cli_gnt) <= 1, 1);
      check("gnt_no_req", cli_gnt & ~cli_req, 0);
      check("gnt_no_arb_req", cli_gnt & ~arb_req, 0);
      check("gnt_over_hold", cli_gnt & full, 0);
      check("err", err, multi_at >= 0 && edges - 1 >= multi_at + LAG);
      blocked = (blocked | xexp) & ~{wd{rst}};
      check("re_request", arb_req & blocked, 0);
      blocked &= cli_req;
      if (rst) check("reset_zero", {arb_req, cli_gnt, cli_exp, err}, 0);
      for (int i = 0; i < wd; i++) run_len[i] = cli_gnt[i] ? run_len[i] + 1 : 0;
      last_gnt = cli_gnt;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, gc, ec;
      int own_t [wd];
      logic seen;
      logic [wd-1:0] served;
      repeat (3) step();
      check("rst_arb_req", arb_req, 0);
      check("rst_cli_gnt", cli_gnt, 0);
      check("rst_cli_exp", cli_exp, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      step();

      cli_req = 4'b0001;
      for (int c = 1; c <= LAG + 2; c++) begin
         step();
         if (c == 1) check("single_arb_req", arb_req, 4'b0001);
         check("single_gnt_latency", cli_gnt, c == LAG + 2 ? 4'b0001 : 4'b0000);
      end
      repeat (2) step();
      cli_req = '0;
      step();
      check("single_drop_arb_req", arb_req, 0);
      check("single_drop_gnt", cli_gnt, 0);
      repeat (6) step();

      cli_req = 4'b0100;
      gc = 0;
      ec = 0;
      repeat (20) begin
         step();
         gc += int'(cli_gnt[2]);
         ec += int'(cli_exp[2]);
      end
      check("hold_gnt_cycles", gc, HOLD);
      check("hold_exp_pulses", ec, 1);
      check("hold_no_rereq", arb_req, 0);
      cli_req = '0;
      repeat (6) step();

      cli_req = 4'b1000;
      n = 0;
      while (!cli_gnt[3] && n < 10) begin step(); n++; end
      check("wd_owner", cli_gnt, 4'b1000);
      cli_req = 4'b1010;
      step();
      check("wd_arb_req_up", arb_req, 4'b1010);
      seen = cli_gnt[1];
      step();
      seen |= cli_gnt[1];
      cli_req = 4'b1000;
      step();
      check("wd_arb_req_down", arb_req[1], 0);
      seen |= cli_gnt[1];
      cli_req = '0;
      repeat (6) begin step(); seen |= cli_gnt[1]; end
      check("wd_never_gnt", seen, 0);

      cli_req = 4'b1111;
      served = '0;
      foreach (own_t[i]) own_t[i] = 0;
      n = 0;
      while (served != 4'b1111 && n < 200) begin
         step();
         n++;
         for (int i = 0; i < wd; i++)
            if (cli_gnt[i]) begin
               served[i] = 1'b1;
               own_t[i]++;
               if (own_t[i] == 3) cli_req[i] = 1'b0;
            end
      end
      check("contention_served", served, 4'b1111);
      check("contention_err", err, 0);
      cli_req = '0;
      repeat (6) step();

      cli_req = 4'b0001;
      n = 0;
      while (!cli_gnt[0] && n < 10) begin step(); n++; end
      check("rst_own_pre", cli_gnt, 4'b0001);
      rst = 1'b1;
      step();
      check("rst_mid_arb_req", arb_req, 0);
      check("rst_mid_gnt", cli_gnt, 0);
      rst = 1'b0;
      step();
      check("rst_rereq", arb_req, 4'b0001);
      n = 0;
      while (!cli_gnt[0] && n < 10) begin step(); n++; end
      check("rst_regrant", cli_gnt, 4'b0001);
      cli_req = '0;
      repeat (6) step();

      fault = 1'b1;
      n = 0;
      while (!err && n < 10) begin step(); n++; end
      check("fault_err_set", err, 1);
      fault = 1'b0;
      repeat (5) step();
      check("fault_err_sticky", err, 1);
      rst = 1'b1;
      step();
      check("fault_err_clear", err, 0);
      rst = 1'b0;
      repeat (4) step();

      for (int c = 0; c < 1500; c++) begin
         step();
         for (int i = 0; i < wd; i++)
            if (!cli_req[i]) cli_req[i] = $urandom_range(0, 3) == 0;
            else if (cli_gnt[i]) cli_req[i] = $urandom_range(0, 11) != 0;
            else cli_req[i] = $urandom_range(0, 29) != 0;
      end
      cli_req = '0;
      repeat (8) step();
      check("final_idle", {arb_req, cli_gnt}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mutex_req_ctl.md
MUTEX_REQ_CTL -- requirements
Module: mutex_req_ctl

Interface
REQ-001 The block SHALL have parameter wd, default 4, giving the number of client ports and arbiter request/grant lines.
REQ-002 The block SHALL have parameter HOLD, default 8, giving the maximum cycles a port may own the grant; 0 means unlimited.
REQ-003 The block SHALL have parameter HW, default 4, giving the hold counter width; HOLD SHALL be at most 2^HW-1.
REQ-004 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port cli_req, input, wd bits: client level request; held high for the whole ownership.
REQ-007 Port cli_gnt, output, wd bits: client owns the arbiter.
REQ-008 Port cli_exp, output, wd bits: one-cycle pulse when the hold limit forces a release.
REQ-009 Port arb_req, output, wd bits: four-phase request to the asynchronous M-to-1 mutex arbiter.
REQ-010 Port arb_gnt, input, wd bits: asynchronous grant from the arbiter.
REQ-011 Port err, output, 1 bit: sticky flag indicating that more than one synchronised grant was seen high.

Function
REQ-012 arb_gnt SHALL be synchronised to clk before any use; gnt_s denotes the synchronised value.
REQ-013 Each port SHALL run an independent FSM with states IDLE, WAIT, OWN and REL, held in registers.
REQ-014 IDLE SHALL go to WAIT when cli_req[i]=1 and gnt_s[i]=0; otherwise the port SHALL stay in IDLE.
REQ-015 WAIT SHALL go to OWN when gnt_s[i]=1.
REQ-016 WAIT SHALL go to REL when cli_req[i]=0 before grant, i.e. a withdrawal handled through the normal return-to-zero phase.
REQ-017 OWN SHALL go to REL when cli_req[i]=0, or when HOLD!=0 and the hold count equals HOLD-1.
REQ-018 REL SHALL go to IDLE only when gnt_s[i]=0 and cli_req[i]=0.
REQ-019 arb_req[i] SHALL be 1 exactly in WAIT and OWN, decoded from the registered state only, so it is glitch-free.
REQ-020 cli_gnt[i] SHALL be 1 exactly in OWN.
REQ-021 The hold counter SHALL clear on entry to OWN, increment each cycle in OWN, and SHALL NOT wrap.
REQ-022 cli_exp[i] SHALL pulse for the single cycle following a forced OWN-to-REL transition; it SHALL NOT pulse on a client release.
REQ-023 Latency: arb_req[i] SHALL rise one cycle after cli_req[i] is sampled high in IDLE.
REQ-024 Latency: cli_gnt[i] SHALL rise in the cycle after gnt_s[i] is sampled high in WAIT.
REQ-025 Simultaneous requests on several ports SHALL all be forwarded; ordering is left to the arbiter.
REQ-026 err SHALL set when the population count of gnt_s exceeds 1 and SHALL stay set until rst.
REQ-027 A port whose request is forced off SHALL NOT re-request until cli_req[i] has been low for at least one cycle.

Reset
REQ-028 While rst=1 at a clock edge, all FSMs SHALL enter IDLE and counters and synchroniser flops SHALL clear.
REQ-029 Reset values SHALL be: arb_req=0, cli_gnt=0, cli_exp=0, err=0.
REQ-030 After a mid-operation reset, a port SHALL remain in IDLE while gnt_s[i]=1, so the arbiter completes its return-to-zero phase first.

Configuration
REQ-031 With macro MUTEX_REQ_SYNC_EN defined, arb_gnt SHALL pass through a two-flop synchroniser, so gnt_s lags arb_gnt by 2 cycles.
REQ-032 Without MUTEX_REQ_SYNC_EN, a single register stage SHALL be used (1-cycle lag), for simulation with a synchronous arbiter model only; all FSM rules SHALL be unchanged.

Verification (wd=4, HOLD=8, MUTEX_REQ_SYNC_EN defined, arbiter model grant delay 1 ns)
REQ-033 Single request: cli_req=0001 at cycle 0 -> arb_req=0001 at cycle 1, cli_gnt=0001 by cycle 4; cli_req dropped -> arb_req=0 the next cycle, IDLE after gnt_s low.
REQ-034 Contention: cli_req=1111 in one cycle -> cli_gnt is one-hot throughout; all four ports served in turn once each releases; err=0.
REQ-035 Hold limit: cli_req=0100 held for 20 cycles -> cli_gnt[2] high for exactly 8 cycles, cli_exp[2] pulses once; no re-request until cli_req[2] goes low.
REQ-036 Withdrawal: cli_req=0010 dropped in WAIT before grant -> port passes through REL, arb_req[1] returns to 0, cli_gnt[1] never rises.
REQ-037 Reset mid-OWN: rst pulsed while port 0 owns -> outputs 0 on the next edge; with cli_req[0]=1, arb_req[0] re-rises only after gnt_s[0]=0.
REQ-038 Fault: arbiter model forces arb_gnt=0011 -> err=1 two cycles later and stays 1 until rst.
